// File: rtl/param_dual_port_ram.sv
// Dual-port synchronous RAM with registered read data, per-port read-during-write
// mode, and write-collision detection with a saturating collision counter.
//
// Output qualifier semantics (no backpressure exists in this block):
//   valid_out_X is 1 in the cycle after an enabled access (read or write) on port X,
//   and data_out_X then holds the word that access produced. When valid_out_X is 0,
//   data_out_X keeps its previous value and carries no new information.
module param_dual_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int READ_MODE  = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable_A,
    input  logic                  write_enable_A,
    input  logic [ADDR_WIDTH-1:0] address_A,
    input  logic [DATA_WIDTH-1:0] data_in_A,
    output logic [DATA_WIDTH-1:0] data_out_A,
    output logic                  valid_out_A,
    input  logic                  enable_B,
    input  logic                  write_enable_B,
    input  logic [ADDR_WIDTH-1:0] address_B,
    input  logic [DATA_WIDTH-1:0] data_in_B,
    output logic [DATA_WIDTH-1:0] data_out_B,
    output logic                  valid_out_B,
    output logic                  collision,
    output logic [7:0]            collision_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_a;
    logic                  wr_b;
    logic                  wr_collide;
    logic                  wr_b_commit;
    logic [DATA_WIDTH-1:0] rd_next_a;
    logic [DATA_WIDTH-1:0] rd_next_b;

    // Decode write strobes; a same-address double write keeps port A's data only.
    always_comb begin
        wr_a        = enable_A && write_enable_A;
        wr_b        = enable_B && write_enable_B;
        wr_collide  = wr_a && wr_b && (address_A == address_B);
        wr_b_commit = wr_b && !wr_collide;
    end

    // Select next read word: array contents are the pre-write value (read-first and
    // all cross-port reads); write-first returns the word actually being stored.
    always_comb begin
        rd_next_a = mem[address_A];
        rd_next_b = mem[address_B];
        if (READ_MODE == 1) begin
            if (wr_a) begin
                rd_next_a = data_in_A;
            end
            if (wr_b) begin
                rd_next_b = wr_collide ? data_in_A : data_in_B;
            end
        end
    end

    // Storage array: reset only suppresses writes, it never clears contents.
    always_ff @(posedge clock or negedge reset_n) begin
        if (reset_n) begin
            if (wr_a) begin
                mem[address_A] <= data_in_A;
            end
            if (wr_b_commit) begin
                mem[address_B] <= data_in_B;
            end
        end
    end

    // Port A output register: load on any enabled access, hold otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_out_A  <= '0;
            valid_out_A <= 1'b0;
        end else begin
            valid_out_A <= enable_A;
            if (enable_A) begin
                data_out_A <= rd_next_a;
            end
        end
    end

    // Port B output register: load on any enabled access, hold otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_out_B  <= '0;
            valid_out_B <= 1'b0;
        end else begin
            valid_out_B <= enable_B;
            if (enable_B) begin
                data_out_B <= rd_next_b;
            end
        end
    end

    // Collision pulse and saturating counter (stops at 255, never wraps).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            collision       <= 1'b0;
            collision_count <= 8'd0;
        end else begin
            collision <= wr_collide;
            if (wr_collide && (collision_count != 8'hFF)) begin
                collision_count <= collision_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_param_dual_port_ram.sv
// Directed bench for param_dual_port_ram: one read-first and one write-first
// instance share the same stimulus; expected values are hand-computed.
module tb_param_dual_port_ram;

  logic       clock;
  logic       reset_n;
  logic       enable_A;
  logic       write_enable_A;
  logic [3:0] address_A;
  logic [7:0] data_in_A;
  logic       enable_B;
  logic       write_enable_B;
  logic [3:0] address_B;
  logic [7:0] data_in_B;

  logic [7:0] r0_dout_a, r0_dout_b, r1_dout_a, r1_dout_b;
  logic       r0_vld_a, r0_vld_b, r1_vld_a, r1_vld_b;
  logic       r0_coll, r1_coll;
  logic [7:0] r0_cnt, r1_cnt;

  int tests = 0;
  int fails = 0;

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  param_dual_port_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_MODE(0)) dut_rf (
    .clock(clock), .reset_n(reset_n),
    .enable_A(enable_A), .write_enable_A(write_enable_A), .address_A(address_A),
    .data_in_A(data_in_A), .data_out_A(r0_dout_a), .valid_out_A(r0_vld_a),
    .enable_B(enable_B), .write_enable_B(write_enable_B), .address_B(address_B),
    .data_in_B(data_in_B), .data_out_B(r0_dout_b), .valid_out_B(r0_vld_b),
    .collision(r0_coll), .collision_count(r0_cnt)
  );

  param_dual_port_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_MODE(1)) dut_wf (
    .clock(clock), .reset_n(reset_n),
    .enable_A(enable_A), .write_enable_A(write_enable_A), .address_A(address_A),
    .data_in_A(data_in_A), .data_out_A(r1_dout_a), .valid_out_A(r1_vld_a),
    .enable_B(enable_B), .write_enable_B(write_enable_B), .address_B(address_B),
    .data_in_B(data_in_B), .data_out_B(r1_dout_b), .valid_out_B(r1_vld_b),
    .collision(r1_coll), .collision_count(r1_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic port_a(input logic en, input logic we, input logic [3:0] addr, input logic [7:0] d);
    enable_A = en; write_enable_A = we; address_A = addr; data_in_A = d;
  endtask

  task automatic port_b(input logic en, input logic we, input logic [3:0] addr, input logic [7:0] d);
    enable_B = en; write_enable_B = we; address_B = addr; data_in_B = d;
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rf_da"}, r0_dout_a, 0);
    check({tag, "_rf_db"}, r0_dout_b, 0);
    check({tag, "_rf_va"}, r0_vld_a, 0);
    check({tag, "_rf_vb"}, r0_vld_b, 0);
    check({tag, "_rf_col"}, r0_coll, 0);
    check({tag, "_rf_cnt"}, r0_cnt, 0);
    check({tag, "_wf_da"}, r1_dout_a, 0);
    check({tag, "_wf_db"}, r1_dout_b, 0);
    check({tag, "_wf_va"}, r1_vld_a, 0);
    check({tag, "_wf_vb"}, r1_vld_b, 0);
    check({tag, "_wf_col"}, r1_coll, 0);
    check({tag, "_wf_cnt"}, r1_cnt, 0);
  endtask

  initial begin
    int exp_cnt;
    reset_n = 1'b0;
    port_a(0, 0, 4'd0, 8'h00);
    port_b(0, 0, 4'd0, 8'h00);
    #1;
    check_all_zero("reset");
    cycle();
    cycle();
    reset_n = 1'b1;

    // write 0x5A to addr 3 on A, then read it on B
    port_a(1, 1, 4'd3, 8'h5A);
    cycle();
    check("wr3_va", r0_vld_a, 1);
    check("wr3_wf_da", r1_dout_a, 8'h5A);
    port_a(0, 0, 4'd0, 8'h00);
    port_b(1, 0, 4'd3, 8'h00);
    cycle();
    check("rd3_rf_db", r0_dout_b, 8'h5A);
    check("rd3_wf_db", r1_dout_b, 8'h5A);
    check("rd3_vb", r0_vld_b, 1);
    check("rd3_va", r0_vld_a, 0);

    // read-during-write on addr 2
    port_b(0, 0, 4'd0, 8'h00);
    port_a(1, 1, 4'd2, 8'hAA);
    cycle();
    port_a(1, 1, 4'd2, 8'hBB);
    port_b(1, 0, 4'd2, 8'h00);
    cycle();
    check("rdw_rf_da", r0_dout_a, 8'hAA);
    check("rdw_wf_da", r1_dout_a, 8'hBB);
    check("rdw_rf_db", r0_dout_b, 8'hAA);
    check("rdw_wf_db", r1_dout_b, 8'hAA);
    check("rdw_col", r0_coll, 0);

    // write collision on addr 7
    port_a(1, 1, 4'd7, 8'h11);
    port_b(1, 1, 4'd7, 8'h22);
    cycle();
    check("col_rf_pulse", r0_coll, 1);
    check("col_wf_pulse", r1_coll, 1);
    check("col_rf_cnt", r0_cnt, 1);
    check("col_wf_cnt", r1_cnt, 1);
    check("col_wf_da", r1_dout_a, 8'h11);
    check("col_wf_db", r1_dout_b, 8'h11);
    port_a(1, 0, 4'd7, 8'h00);
    port_b(1, 0, 4'd7, 8'h00);
    cycle();
    check("col_once", r0_coll, 0);
    check("col_cnt_hold", r0_cnt, 1);
    check("rd7_rf_da", r0_dout_a, 8'h11);
    check("rd7_rf_db", r0_dout_b, 8'h11);
    check("rd7_wf_db", r1_dout_b, 8'h11);

    // writes to different addresses: no collision
    port_a(1, 1, 4'd8, 8'h33);
    port_b(1, 1, 4'd9, 8'h44);
    cycle();
    check("diff_col", r0_coll, 0);
    check("diff_cnt", r1_cnt, 1);
    check("diff_wf_da", r1_dout_a, 8'h33);
    check("diff_wf_db", r1_dout_b, 8'h44);

    // hold: read addr 8 then idle A for 3 cycles with a masked write request
    port_b(0, 0, 4'd0, 8'h00);
    port_a(1, 0, 4'd8, 8'h00);
    cycle();
    check("hold_rd_da", r0_dout_a, 8'h33);
    check("hold_rd_va", r0_vld_a, 1);
    port_a(0, 1, 4'd8, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("hold_da", r0_dout_a, 8'h33);
      check("hold_va", r0_vld_a, 0);
    end
    port_a(1, 0, 4'd8, 8'h00);
    cycle();
    check("hold_nowr", r0_dout_a, 8'h33);

    // saturation: 300 same-address dual writes to addr 5
    for (int i = 0; i < 300; i++) begin
      port_a(1, 1, 4'd5, i[7:0]);
      port_b(1, 1, 4'd5, ~i[7:0]);
      cycle();
      exp_cnt = (i + 2 > 255) ? 255 : i + 2;
      check("sat_pulse", r0_coll, 1);
      check("sat_cnt", r0_cnt, exp_cnt[7:0]);
    end
    port_a(1, 0, 4'd5, 8'h00);
    port_b(0, 0, 4'd0, 8'h00);
    cycle();
    check("sat_end_col", r0_coll, 0);
    check("sat_end_cnt", r1_cnt, 8'hFF);
    check("sat_rd5", r0_dout_a, 8'h2B);

    // async reset mid-cycle with a pending write
    port_a(1, 0, 4'd3, 8'h00);
    cycle();
    check("pre_rst_va", r0_vld_a, 1);
    port_a(1, 1, 4'd3, 8'hEE);
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("arst");
    cycle();
    check_all_zero("arst_edge");
    reset_n = 1'b1;
    port_a(1, 0, 4'd3, 8'h00);
    port_b(1, 0, 4'd7, 8'h00);
    cycle();
    check("post_rst_rf_da", r0_dout_a, 8'h5A);
    check("post_rst_wf_da", r1_dout_a, 8'h5A);
    check("post_rst_va", r0_vld_a, 1);
    check("post_rst_db", r0_dout_b, 8'h11);
    check("post_rst_cnt", r0_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
